// File: rtl/jpeg_pkg.sv
// Purpose : shared constants and helpers for the JPEG bitstream front end.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package jpeg_pkg;

  // Window presented to the parsers, and the backing store behind it.
  localparam int WIN_W = 64;
  localparam int BUF_W = 128;

  // First byte of every marker, and the stuffing byte that follows a
  // literal 0xFF inside entropy-coded data.
  localparam logic [7:0] JPEG_MARKER_PFX = 8'hFF;
  localparam logic [7:0] JPEG_STUFF      = 8'h00;

  function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jpeg_destuff.sv
// Purpose : tracks 0xFF prefixes, drops 0xFF00 stuffing, flags markers.
// Latency : append is combinational with the accept; marker_det/code one cycle later.
// Backpressure: none; acts only on bytes the parent has already accepted.
//
// Ports:
//   clk, rst     - clock, synchronous active-high clear (parent ORs in flush)
//   data         - byte being accepted this cycle
//   accept       - handshake strobe for data
//   destuff_en   - high while inside entropy-coded data
//   append       - accepted byte must be written into the bit buffer
//   marker_det   - one-cycle pulse after a marker byte follows a 0xFF
//   marker_code  - second byte of the most recent marker
module jpeg_destuff
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       accept,
  input  logic       destuff_en,
  output logic       append,
  output logic       marker_det,
  output logic [7:0] marker_code
);

  logic       prev_ff_q;
  logic       marker_det_q;
  logic [7:0] marker_code_q;

  logic after_ff;
  logic is_stuff;
  logic marker_hit;

  // A byte that directly follows an accepted 0xFF in entropy-coded data is
  // either stuffing (0x00, thrown away) or the second half of a marker.
  assign after_ff   = accept && destuff_en && prev_ff_q;
  assign is_stuff   = (data == JPEG_STUFF);
  assign marker_hit = after_ff && !is_stuff;
  assign append     = accept && !(after_ff && is_stuff);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ff_q     <= 1'b0;
      marker_det_q  <= 1'b0;
      marker_code_q <= 8'h00;
    end else begin
      // Any accepted byte other than an in-segment 0xFF breaks the pair.
      if (accept) begin
        prev_ff_q <= destuff_en && (data == JPEG_MARKER_PFX);
      end
      marker_det_q <= marker_hit;
      if (marker_hit) begin
        marker_code_q <= data;
      end
    end
  end

  assign marker_det  = marker_det_q;
  assign marker_code = marker_code_q;

endmodule

// File: rtl/jpeg_bitbuf.sv
// Purpose : byte-in, bit-out window buffer feeding the JPEG parsers / Huffman decoder.
// Latency : accepted byte and consumed bits are reflected in win/fill right after the edge.
// Backpressure: in_ready drops when fewer than 8 free bits remain, after end of stream, or during clear.
//
// Ports:
//   clk, rst, flush         - clock, synchronous active-high reset, per-image clear
//   in_data/valid/last      - compressed byte stream; in_ready is the handshake
//   destuff_en              - enables 0xFF00 removal and marker detection
//   pc_delta                - bits to consume this cycle (honoured when bit_avali)
//   bit_avali, win, fill    - window valid, MSB-first window, stored bit count
//   marker_det, marker_code - marker pulse and its second byte
//   err_delta               - sticky over-consume error
module jpeg_bitbuf #(
  parameter int WIN_W = jpeg_pkg::WIN_W,
  parameter int BUF_W = jpeg_pkg::BUF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             destuff_en,
  input  logic [7:0]       pc_delta,
  output logic             bit_avali,
  output logic [WIN_W-1:0] win,
  output logic [7:0]       fill,
  output logic             marker_det,
  output logic [7:0]       marker_code,
  output logic             err_delta
);

  import jpeg_pkg::*;

  if (BUF_W < WIN_W + 8) begin : g_bad_depth
    $error("jpeg_bitbuf: BUF_W must be at least WIN_W + 8");
  end

  localparam logic [7:0] WIN_N  = 8'(WIN_W);
  localparam logic [7:0] ROOM_N = 8'(BUF_W - 8);

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [7:0]       fill_q, fill_d;
  logic             eos_q, eos_d;
  logic             err_q, err_d;

  logic       clr;
  logic       accept;
  logic       append;
  logic [7:0] consume;
  logic [7:0] keep;
  logic       bad_delta;

  assign clr = rst | flush;

  // Both handshake outputs come from registers (plus the clear) only, so
  // there is no loop through the upstream pc_delta logic.
  assign bit_avali = (fill_q >= WIN_N) || (eos_q && (fill_q != 8'd0));
  assign in_ready  = !clr && !eos_q && (fill_q <= ROOM_N);
  assign accept    = in_valid && in_ready;

  // Clamp to what is stored so fill can never underflow, even on error.
  assign consume = bit_avali ? min_u8(pc_delta, fill_q) : 8'd0;
  assign keep    = fill_q - consume;

  assign bad_delta = bit_avali &&
                     ((pc_delta > WIN_N) || (eos_q && (pc_delta > fill_q)));

  jpeg_destuff u_destuff (
    .clk         (clk),
    .rst         (clr),
    .data        (in_data),
    .accept      (accept),
    .destuff_en  (destuff_en),
    .append      (append),
    .marker_det  (marker_det),
    .marker_code (marker_code)
  );

  always_comb begin
    bits_d = bits_q << consume;
    fill_d = keep;
    // Bits at and beyond fill are kept zero before end of stream, so the new
    // byte can simply be ORed in just below the surviving bits.
    if (append) begin
      bits_d = bits_d | ({in_data, {(BUF_W-8){1'b0}}} >> keep);
      fill_d = keep + 8'd8;
    end
    eos_d = eos_q | (accept & in_last);
    // After end of stream the tail reads as 1s (JPEG fill bits). Re-applying
    // the mask every cycle also covers the zeros shifted in by consumption.
    if (eos_d) begin
      bits_d = bits_d | ({BUF_W{1'b1}} >> fill_d);
    end
    err_d = err_q | bad_delta;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bits_q <= '0;
      fill_q <= 8'd0;
      eos_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
      eos_q  <= eos_d;
      err_q  <= err_d;
    end
  end

  assign win       = bits_q[BUF_W-1 -: WIN_W];
  assign fill      = fill_q;
  assign err_delta = err_q;

endmodule

// File: doc/jpeg_bitbuf.md
# jpeg_bitbuf

Bitstream window buffer that feeds the JPEG header parsers and Huffman decoder. It accepts the compressed file one byte per cycle and removes 0xFF00 byte stuffing inside entropy-coded segments. It presents a 64-bit MSB-first window of the next unread bits, and each cycle it advances by the `pc_delta` bit count returned by the program-counter logic. `bit_avali` tells that logic when the window holds valid bits.

## Interface
- `WIN_W`, 64: window width in bits; maximum legal `pc_delta`.
- `BUF_W`, 128: internal bit storage depth; must be ≥ WIN_W + 8.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear for a new image; same effect as `rst`.
- `in_data` in 8: next file byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: qualifies the final byte of the file.
- `in_ready` out 1: byte accepted when `in_valid && in_ready` at the rising edge.
- `destuff_en` in 1: high while decoding entropy-coded data.
- `pc_delta` in 8: bits to consume this cycle; honoured only when `bit_avali` is high.
- `bit_avali` out 1: window valid.
- `win` out WIN_W: unread bits; `win[WIN_W-1]` is the next bit.
- `fill` out 8: count of valid bits stored, 0..BUF_W.
- `marker_det` out 1: one-cycle pulse when a marker is found in stuffed data.
- `marker_code` out 8: second byte of the last marker found.
- `err_delta` out 1: sticky protocol error flag.

## Operation
- Storage is `buf[BUF_W-1:0]`, left-aligned. `win = buf[BUF_W-1 -: WIN_W]`.
- `bit_avali = (fill >= WIN_W) || (eos && fill != 0)`.
- `in_ready = !eos && (fill <= BUF_W-8)`.
  - Computed from registers only; no path from `pc_delta`, which is combinational on `win` upstream.
- Consume count:
  - `c = bit_avali ? min(pc_delta, fill) : 0`.
  - `pc_delta` values are 0..64, so `c` fits in 8 bits and `fill - c` cannot underflow.
- Append rule: an accepted byte that is not dropped is written at bits `[BUF_W-1-(fill-c) -: 8]` of the shifted buffer.
- Per cycle: `buf <= (buf << c)` with the byte appended; `fill <= fill - c + (appended ? 8 : 0)`.
- Consume and append may occur in the same cycle.
- Destuffing:
  - `prev_ff` register is set when an accepted byte is 0xFF under `destuff_en`; it is cleared by any other accepted byte.
  - Accepted 0x00 with `prev_ff` and `destuff_en` high is dropped: handshake completes, nothing is appended, fill is unchanged by the append.
  - Accepted non-zero byte with `prev_ff` and `destuff_en` high is appended. It also pulses `marker_det` the next cycle and loads `marker_code`.
  - With `destuff_en` low, every byte is appended.
- End of stream: accepting a byte with `in_last` sets `eos`. While `eos` is set, bit positions at or beyond `fill` read as 1s, matching JPEG fill convention.
- Errors: `err_delta` sets when either condition holds, and stays set until `rst` or `flush`:
  - `bit_avali && pc_delta > WIN_W`, or
  - `bit_avali && eos && pc_delta > fill`.
- On error, consumption is still clamped as above.

## Timing
- Reset values:
  - `buf` = 0, `fill` = 0, `eos` = 0, `prev_ff` = 0.
  - `bit_avali` = 0, `in_ready` = 1, `marker_det` = 0, `marker_code` = 0, `err_delta` = 0.
- A byte accepted at edge N is visible in `win`/`fill` after edge N. Consumption at edge N is visible after edge N.
- Startup: 8 accepted bytes give `fill` = 64, so `bit_avali` is high in the cycle after the 8th acceptance.
- `bit_avali` and `in_ready` are combinational from registers only. `win` is a direct register slice.
- `rst` or `flush` mid-stream discards all buffered bits, `eos`, and `prev_ff` at that edge. A byte presented in the same cycle is not accepted (`in_ready` is forced low).

## Structure
- Shared package `jpeg_pkg` holds `WIN_W`, `BUF_W`, `JPEG_MARKER_PFX` = 8'hFF, and `JPEG_STUFF` = 8'h00. The existing state-encoding defines stay where they are.
- One sub-module, `jpeg_destuff`:
  - Inputs: byte, `destuff_en`, and the accept strobe.
  - Internal state: `prev_ff`.
  - Outputs: `append`, `marker_det`, `marker_code`.
- Shift/append datapath and fill counter stay in the top module.

## Test plan
- Startup fill: bytes 01..08, `pc_delta` = 0 → `bit_avali` high after the 8th byte, `win` = 64'h0102030405060708, `fill` = 64.
- Consume plus append in one cycle:
  - `pc_delta` = 16 while byte 09 is accepted → `fill` = 56, `win[63:8]` = 56'h03040506070809, `bit_avali` low.
  - Next byte 0A → `fill` = 64, `bit_avali` high.
- Destuffing: `destuff_en` = 1, bytes FF 00 12 → `fill` = 16, `win[63:48]` = 16'hFF12, `marker_det` never pulses.
- Marker: `destuff_en` = 1, bytes FF D9 → `marker_det` pulses once, `marker_code` = D9, `fill` = 16, `win[63:48]` = 16'hFFD9.
- End of stream: bytes AB CD EF with `in_last` on EF → `bit_avali` high at `fill` = 24, `win` = 64'hABCDEF_FFFFFFFFFF, `in_ready` low.
  - `pc_delta` = 24 → `fill` = 0, `bit_avali` low.
- Error and reset:
  - With `fill` = 64, `pc_delta` = 65 → `err_delta` set, `fill` = 0.
  - Then `rst` mid-stream while `in_valid` is high → all outputs at reset values, no byte accepted that cycle.
